// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, default width.
package alu_arb_pkg;

    localparam int unsigned DefaultDataW = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: add/sub/and/or with carry, zero and sign flags.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int unsigned DataW = DefaultDataW
) (
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [DataW-1:0] res_o,
    output logic             cf_o,
    output logic             zf_o,
    output logic             sf_o
);

    logic [DataW:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        res_o = '0;
        cf_o  = 1'b0;
        sf_o  = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                res_o = sum[DataW-1:0];
                cf_o  = sum[DataW];
            end
            OP_SUB: begin
                // Negative differences are reported as magnitude plus sign flag.
                if (a_i < b_i) begin
                    res_o = b_i - a_i;
                    sf_o  = 1'b1;
                end else begin
                    res_o = a_i - b_i;
                end
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            default: res_o = '0;
        endcase
    end

    assign zf_o = (res_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU; one transaction in flight (IDLE/EXEC/RESP).
// Optional grant statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_cf,
    output logic              rsp_zf,
    output logic              rsp_sf
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1
`endif
);

    state_e state_q, state_d;
    logic   rr_ptr_q, rr_ptr_d;

    logic [DATA_W-1:0] cap_a_q, cap_a_d;
    logic [DATA_W-1:0] cap_b_q, cap_b_d;
    logic [1:0]        cap_op_q, cap_op_d;
    logic              cap_id_q, cap_id_d;

    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
    logic              rsp_cf_q, rsp_cf_d;
    logic              rsp_zf_q, rsp_zf_d;
    logic              rsp_sf_q, rsp_sf_d;

    logic [1:0]        grant;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cf;
    logic              alu_zf;
    logic              alu_sf;

    // Grant is combinational and only offered from IDLE outside reset.
    always_comb begin
        grant = 2'b00;
        if (rst_n && (state_q == StIdle)) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|grant) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        cap_a_d   = cap_a_q;
        cap_b_d   = cap_b_q;
        cap_op_d  = cap_op_q;
        cap_id_d  = cap_id_q;
        rsp_id_d  = rsp_id_q;
        rsp_res_d = rsp_res_q;
        rsp_cf_d  = rsp_cf_q;
        rsp_zf_d  = rsp_zf_q;
        rsp_sf_d  = rsp_sf_q;
        if (|grant) begin
            cap_a_d  = grant[1] ? req_a1  : req_a0;
            cap_b_d  = grant[1] ? req_b1  : req_b0;
            cap_op_d = grant[1] ? req_op1 : req_op0;
            cap_id_d = grant[1];
            rr_ptr_d = ~grant[1];
        end
        if (state_q == StExec) begin
            rsp_id_d  = cap_id_q;
            rsp_res_d = alu_res;
            rsp_cf_d  = alu_cf;
            rsp_zf_d  = alu_zf;
            rsp_sf_d  = alu_sf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 1'b0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
            cap_op_q  <= 2'b00;
            cap_id_q  <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_res_q <= '0;
            rsp_cf_q  <= 1'b0;
            rsp_zf_q  <= 1'b0;
            rsp_sf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cap_a_q   <= cap_a_d;
            cap_b_q   <= cap_b_d;
            cap_op_q  <= cap_op_d;
            cap_id_q  <= cap_id_d;
            rsp_id_q  <= rsp_id_d;
            rsp_res_q <= rsp_res_d;
            rsp_cf_q  <= rsp_cf_d;
            rsp_zf_q  <= rsp_zf_d;
            rsp_sf_q  <= rsp_sf_d;
        end
    end

    alu_core #(
        .DataW (DATA_W)
    ) u_alu_core (
        .a_i   (cap_a_q),
        .b_i   (cap_b_q),
        .op_i  (cap_op_q),
        .res_o (alu_res),
        .cf_o  (alu_cf),
        .zf_o  (alu_zf),
        .sf_o  (alu_sf)
    );

    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_cf    = rsp_cf_q;
    assign rsp_zf    = rsp_zf_q;
    assign rsp_sf    = rsp_sf_q;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    // Counters wrap naturally at 8 bits.
    always_comb begin
        cnt0_d = cnt0_q + 8'(grant[0]);
        cnt1_d = cnt1_q + 8'(grant[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: grant observer pushes model results, response monitor pops.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0] req_op0, req_op1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_res;
    logic       rsp_cf, rsp_zf, rsp_sf;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif

    alu_arbiter #(
        .DATA_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_cf    (rsp_cf),
        .rsp_zf    (rsp_zf),
        .rsp_sf    (rsp_sf)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       id;
        logic [3:0] res;
        logic       cf;
        logic       zf;
        logic       sf;
        int         gcyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   finishing = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference ALU written straight from the arithmetic rules.
    function automatic exp_t model(input int id, input int a, input int b, input int op,
                                   input int gc);
        exp_t e;
        int   r = 0;
        e.cf = 1'b0;
        e.sf = 1'b0;
        case (op)
            0: begin
                r = (a + b) % 16;
                e.cf = (a + b) > 15;
            end
            1: begin
                if (a >= b) r = a - b;
                else begin
                    r = b - a;
                    e.sf = 1'b1;
                end
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        e.id   = id[0];
        e.res  = r[3:0];
        e.zf   = (r == 0);
        e.gcyc = gc;
        return e;
    endfunction

    // Grant observer: arbitration model and scoreboard producer.
    bit busy = 1'b0;
    int pref = 0;
    int mcnt0 = 0;
    int mcnt1 = 0;

    always @(negedge clk) begin
        int exp_g;
        int w;
        if (!rst_n) begin
            chk("ready_in_reset", req_ready, 0);
            q.delete();
            busy  = 1'b0;
            pref  = 0;
            mcnt0 = 0;
            mcnt1 = 0;
        end else begin
`ifdef ALU_ARB_STATS_EN
            chk("grant_cnt0", grant_cnt0, mcnt0);
            chk("grant_cnt1", grant_cnt1, mcnt1);
`endif
            if (busy) exp_g = 0;
            else begin
                case (req_valid)
                    2'b01:   exp_g = 1;
                    2'b10:   exp_g = 2;
                    2'b11:   exp_g = (pref == 1) ? 2 : 1;
                    default: exp_g = 0;
                endcase
            end
            chk("req_ready", req_ready, exp_g);
            if (exp_g != 0) begin
                w = (exp_g == 2) ? 1 : 0;
                if (w == 1) q.push_back(model(1, req_a1, req_b1, req_op1, cyc));
                else        q.push_back(model(0, req_a0, req_b0, req_op0, cyc));
                busy = 1'b1;
                pref = 1 - w;
                if (w == 1) mcnt1 = (mcnt1 + 1) % 256;
                else        mcnt0 = (mcnt0 + 1) % 256;
            end else if (busy && rsp_valid && rsp_ready) begin
                busy = 1'b0;
            end
        end
    end

    // Response monitor: scoreboard consumer plus hold/reset checks.
    bit         pv = 1'b0;
    bit         pr = 1'b0;
    bit         prst_low = 1'b0;
    bit         done_chk = 1'b0;
    logic [7:0] pout = 8'd0;
    int         rise = 0;

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] cur;
        cur = {rsp_id, rsp_res, rsp_cf, rsp_zf, rsp_sf};
        if (prst_low) begin
            chk("reset_outputs", {rsp_valid, cur}, 0);
        end else if (rst_n) begin
            if (pv && !pr) begin
                chk("stall_valid", rsp_valid, 1);
                chk("stall_outputs", cur, pout);
            end
            if (pv && pr) begin
                chk("valid_drop", rsp_valid, 0);
                chk("outputs_kept", cur, pout);
            end
            if (rsp_valid && !pv) rise = cyc;
            if (q.size() == 0) begin
                chk("spurious_rsp", rsp_valid, 0);
            end else if (rsp_valid && rsp_ready) begin
                e = q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_res", rsp_res, e.res);
                chk("rsp_cf", rsp_cf, e.cf);
                chk("rsp_zf", rsp_zf, e.zf);
                chk("rsp_sf", rsp_sf, e.sf);
                chk("latency", rise - e.gcyc, 2);
            end
        end
        if (finishing && !done_chk) begin
            chk("queue_drained", q.size(), 0);
            done_chk = 1'b1;
        end
        pv       = rsp_valid;
        pr       = rsp_ready;
        pout     = cur;
        prst_low = !rst_n;
    end

    task automatic set_req(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                           input logic [1:0] op0, input logic [3:0] a1, input logic [3:0] b1,
                           input logic [1:0] op1);
        req_valid = v;
        req_a0 = a0; req_b0 = b0; req_op0 = op0;
        req_a1 = a1; req_b1 = b1; req_op1 = op1;
    endtask

    task automatic wait_grant(input int idx);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready[idx]) break;
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_req(2'b00, 4'd0, 4'd0, OP_ADD, 4'd0, 4'd0, OP_ADD);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requesters, including carry, negative and zero results.
        set_req(2'b01, 4'd9, 4'd8, OP_ADD, 4'd0, 4'd0, OP_ADD);
        wait_grant(0);
        wait_done();
        set_req(2'b10, 4'd0, 4'd0, OP_ADD, 4'd3, 4'd5, OP_SUB);
        wait_grant(1);
        wait_done();
        set_req(2'b10, 4'd0, 4'd0, OP_ADD, 4'd5, 4'd5, OP_SUB);
        wait_grant(1);
        wait_done();

        // Both valid from reset: grants alternate starting at requester 0.
        do_reset();
        set_req(2'b11, 4'b1010, 4'b0110, OP_AND, 4'b1010, 4'b0101, OP_OR);
        repeat (13) @(posedge clk);
        #1 req_valid = 2'b00;
        wait_done();

        // Consumer stall with a pending request that must wait for IDLE.
        rsp_ready = 1'b0;
        set_req(2'b01, 4'd4, 4'd3, OP_SUB, 4'd0, 4'd0, OP_ADD);
        wait_grant(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 set_req(2'b10, 4'd0, 4'd0, OP_ADD, 4'd7, 4'd7, OP_AND);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grant(1);
        wait_done();

        // Reset while in EXEC discards the transaction and rewinds the pointer.
        set_req(2'b01, 4'd2, 4'd2, OP_ADD, 4'd0, 4'd0, OP_ADD);
        wait_grant(0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(2'b11, 4'd1, 4'd6, OP_OR, 4'd8, 4'd9, OP_SUB);
        wait_grant(0);
        wait_done();

        // Long run of requester-0 grants exercises counter wrap when enabled.
        for (int i = 0; i < 257; i++) begin
            set_req(2'b01, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 4'd0, 4'd0, OP_ADD);
            wait_grant(0);
            wait_done();
        end

        // Randomised traffic with stalls and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            set_req(2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end

        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        finishing = 1'b1;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
